// File: rtl/bus_pkg.sv
// Shared widths, FSM state encoding and constants for the serial bus master port.
// The read-timeout value is only used when MASTER_PORT_TIMEOUT_EN is defined.
package bus_pkg;

   localparam int unsigned BUS_ADDR_WIDTH = 12;
   localparam int unsigned BUS_DATA_WIDTH = 8;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      REQ     = 3'd1,
      ADDR    = 3'd2,
      WAIT_RD = 3'd3,
      SPLIT   = 3'd4,
      REGRANT = 3'd5,
      RX      = 3'd6,
      DONE    = 3'd7
   } mp_state_e;

   localparam logic [BUS_DATA_WIDTH-1:0] TIMEOUT_RDATA = '1;

endpackage

// File: rtl/master_shift_unit.sv
// Address/write-data serialiser and read-data deserialiser sharing one bit counter.
module master_shift_unit
   import bus_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = BUS_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = BUS_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic                  mode,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  shift,
   input  logic                  rx_sample,
   input  logic                  rx_first,
   input  logic                  rx_bit,
   output logic                  tx_address,
   output logic                  tx_data,
   output logic                  tx_last,
   output logic                  rx_last,
   output logic [DATA_WIDTH-1:0] rx_word
);

   localparam int unsigned MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
   localparam int unsigned CNT_W = $clog2(MAX_W + 1);

   logic [ADDR_WIDTH-1:0] addr_sr;
   logic [DATA_WIDTH-1:0] data_sr;
   logic [DATA_WIDTH-2:0] shadow;
   logic [CNT_W-1:0]      cnt;

   assign tx_address = addr_sr[0];
   assign tx_data    = data_sr[0];
   assign tx_last    = (cnt == CNT_W'(ADDR_WIDTH - 1));
   // Bit 0 arrives in WAIT_RD, so the first sample can never be the last one.
   assign rx_last    = rx_sample && !rx_first && (cnt == CNT_W'(DATA_WIDTH - 1));
   assign rx_word    = {rx_bit, shadow};

   always_ff @(posedge clk) begin
      if (reset) begin
         addr_sr <= '0;
         data_sr <= '0;
         shadow  <= '0;
         cnt     <= '0;
      end else if (load) begin
         addr_sr <= addr;
         data_sr <= mode ? wdata : '0;
         cnt     <= '0;
      end else if (shift) begin
         addr_sr <= addr_sr >> 1;
         data_sr <= data_sr >> 1;
         cnt     <= cnt + CNT_W'(1);
      end else if (rx_sample) begin
         shadow <= rx_word[DATA_WIDTH-1:1];
         cnt    <= rx_first ? CNT_W'(1) : cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/master_port.sv
// Bus-side initiator port: arbitrates, serialises address/write data, deserialises read data.
// Define MASTER_PORT_TIMEOUT_EN to add the read-wait timeout counter and the timeout output.
module master_port
   import bus_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = BUS_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = BUS_DATA_WIDTH
`ifdef MASTER_PORT_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req,
   input  logic                  mode,
   input  logic [ADDR_WIDTH-1:0] addr_in,
   input  logic [DATA_WIDTH-1:0] wdata_in,
   output logic                  bus_req,
   input  logic                  bus_grant,
   input  logic                  slave_ready,
   input  logic                  slave_valid,
   input  logic                  split_en,
   input  logic                  rx_data,
   output logic                  master_valid,
   output logic                  master_ready,
   output logic                  read_en,
   output logic                  write_en,
   output logic                  tx_address,
   output logic                  tx_data,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  done,
`ifdef MASTER_PORT_TIMEOUT_EN
   output logic                  timeout,
`endif
   output logic                  busy
);

   mp_state_e             state;
   logic                  mode_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  bus_req_q, valid_q, ready_q, read_en_q, write_en_q, done_q, busy_q;
   logic                  load, shift, rx_first, rx_sample, tx_last, rx_last;
   logic                  sh_address, sh_data;
   logic [DATA_WIDTH-1:0] rx_word;

   assign load      = (state == REQ) && bus_grant && slave_ready;
   assign shift     = (state == ADDR);
   assign rx_first  = (state == WAIT_RD) && slave_valid;
   assign rx_sample = rx_first || ((state == RX) && slave_valid);

   // Re-request is raised in the same cycle the slave signals it is ready after a split.
   assign bus_req      = bus_req_q || ((state == SPLIT) && slave_valid);
   assign master_valid = valid_q;
   assign master_ready = ready_q;
   assign read_en      = read_en_q;
   assign write_en     = write_en_q;
   assign tx_address   = valid_q && sh_address;
   assign tx_data      = valid_q && sh_data;
   assign done         = done_q;
   assign busy         = busy_q;

   master_shift_unit #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_shift (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .mode       (mode_q),
      .addr       (addr_q),
      .wdata      (wdata_q),
      .shift      (shift),
      .rx_sample  (rx_sample),
      .rx_first   (rx_first),
      .rx_bit     (rx_data),
      .tx_address (sh_address),
      .tx_data    (sh_data),
      .tx_last    (tx_last),
      .rx_last    (rx_last),
      .rx_word    (rx_word)
   );

`ifdef MASTER_PORT_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TMO_W-1:0] tmo_cnt;
   logic             waiting, enter_wait, expire, timeout_q;

   assign waiting    = (state == WAIT_RD) || (state == SPLIT) || (state == REGRANT);
   assign enter_wait = ((state == ADDR) && tx_last && !mode_q) ||
                       ((state == WAIT_RD) && !slave_valid && split_en) ||
                       ((state == SPLIT) && slave_valid) ||
                       ((state == REGRANT) && bus_grant);
   assign expire     = waiting && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
   assign timeout    = timeout_q;

   always_ff @(posedge clk) begin
      if (reset || enter_wait) begin
         tmo_cnt <= '0;
      end else if (waiting) begin
         tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         mode_q     <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         bus_req_q  <= 1'b0;
         valid_q    <= 1'b0;
         ready_q    <= 1'b0;
         read_en_q  <= 1'b0;
         write_en_q <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         rdata      <= '0;
`ifdef MASTER_PORT_TIMEOUT_EN
         timeout_q  <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
`ifdef MASTER_PORT_TIMEOUT_EN
         timeout_q <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (req) begin
                  mode_q    <= mode;
                  addr_q    <= addr_in;
                  wdata_q   <= wdata_in;
                  bus_req_q <= 1'b1;
                  busy_q    <= 1'b1;
                  state     <= REQ;
               end
            end
            REQ: begin
               if (bus_grant && slave_ready) begin
                  valid_q    <= 1'b1;
                  read_en_q  <= !mode_q;
                  write_en_q <= mode_q;
                  state      <= ADDR;
               end
            end
            ADDR: begin
               // The frame runs to completion regardless of bus_grant.
               if (tx_last) begin
                  valid_q    <= 1'b0;
                  read_en_q  <= 1'b0;
                  write_en_q <= 1'b0;
                  if (mode_q) begin
                     bus_req_q <= 1'b0;
                     done_q    <= 1'b1;
                     state     <= DONE;
                  end else begin
                     ready_q <= 1'b1;
                     state   <= WAIT_RD;
                  end
               end
            end
            WAIT_RD: begin
               if (slave_valid) begin
                  state <= RX;
               end else if (split_en) begin
                  bus_req_q <= 1'b0;
                  state     <= SPLIT;
               end
            end
            SPLIT: begin
               if (slave_valid) begin
                  bus_req_q <= 1'b1;
                  state     <= REGRANT;
               end
            end
            REGRANT: begin
               if (bus_grant) begin
                  state <= WAIT_RD;
               end
            end
            RX: begin
               if (rx_last) begin
                  rdata     <= rx_word;
                  bus_req_q <= 1'b0;
                  ready_q   <= 1'b0;
                  done_q    <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
`ifdef MASTER_PORT_TIMEOUT_EN
         if (expire) begin
            rdata     <= DATA_WIDTH'(TIMEOUT_RDATA);
            bus_req_q <= 1'b0;
            ready_q   <= 1'b0;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
            state     <= DONE;
         end
`endif
      end
   end

endmodule
